// File: rtl/blk_addr_alloc_pkg.sv
// Shared sizing and FSM state type for the SRAM block allocator.
// Consumers import this package with import blk_addr_alloc_pkg::*.
package blk_addr_alloc_pkg;

  localparam int BLK_ADDR_WIDTH = 4;
  localparam int BLK_NUM        = 2**BLK_ADDR_WIDTH;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/blk_addr_alloc_if.sv
// Request/grant and release strobes between a channel and the allocator.
// The slave modport is the allocator side.
interface blk_addr_alloc_if
  import blk_addr_alloc_pkg::*;
#(
  parameter int AW = BLK_ADDR_WIDTH
);

  logic          i_addr_req;
  logic          o_blk_addr_vld;
  logic [AW-1:0] o_blk_addr;
  logic          i_rel_vld;
  logic [AW-1:0] i_rel_addr;

  modport slave (
    input  i_addr_req,
    input  i_rel_vld,
    input  i_rel_addr,
    output o_blk_addr_vld,
    output o_blk_addr
  );

  modport master (
    output i_addr_req,
    output i_rel_vld,
    output i_rel_addr,
    input  o_blk_addr_vld,
    input  o_blk_addr
  );

endinterface

// File: rtl/blk_free_fifo.sv
// Circular free-list FIFO with show-ahead head and occupancy count.
// Callers never write when full or read when empty.
module blk_free_fifo #(
  parameter int AW = 4,
  parameter int N  = 2**AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic [AW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [AW-1:0] o_head,
  output logic [AW:0]   o_cnt
);

  logic [AW-1:0] r_mem [N];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;

  // Storage is rewritten by the allocator's init pass, so no reset here.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({i_wr, i_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/blk_addr_alloc.sv
// SRAM block address allocator: init pass, grant/pending logic,
// empty-list bypass of released addresses and sticky error flags.
module blk_addr_alloc #(
  parameter int BLK_ADDR_WIDTH = blk_addr_alloc_pkg::BLK_ADDR_WIDTH,
  parameter int BLK_NUM        = 2**BLK_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  blk_addr_alloc_if.slave       bus,
  output logic [BLK_ADDR_WIDTH:0] o_free_cnt,
  output logic                  o_empty,
  output logic                  o_init_done,
  output logic                  o_req_ovf,
  output logic                  o_rel_err
);

  import blk_addr_alloc_pkg::*;

  localparam int AW = BLK_ADDR_WIDTH;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(BLK_NUM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BLK_NUM-1);

  alloc_state_e  r_state;
  alloc_state_e  w_state_nxt;

  logic [AW-1:0] r_init_addr;
  logic          r_pend;
  logic          r_vld;
  logic [AW-1:0] r_addr;
  logic          r_init_done;
  logic          r_req_ovf;
  logic          r_rel_err;

  logic          w_wr;
  logic          w_rd;
  logic [AW-1:0] w_wdata;
  logic [AW-1:0] w_head;
  logic [AW:0]   w_cnt;
  logic          w_has_free;
  logic          w_full;
  logic          w_want;
  logic          w_grant;
  logic          w_bypass;
  logic          w_rel_ok;
  logic          w_pend_nxt;
  logic          w_ovf_set;
  logic          w_rel_err_set;
  logic [AW-1:0] w_gnt_addr;

  blk_free_fifo #(
    .AW (AW),
    .N  (BLK_NUM)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (w_rd),
    .o_head  (w_head),
    .o_cnt   (w_cnt)
  );

  assign w_has_free = (w_cnt != '0);
  assign w_full     = (w_cnt == FULL_CNT);
  assign w_ovf_set  = bus.i_addr_req & r_pend;
  assign w_gnt_addr = w_bypass ? bus.i_rel_addr : w_head;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr          = 1'b0;
    w_rd          = 1'b0;
    w_wdata       = bus.i_rel_addr;
    w_want        = 1'b0;
    w_grant       = 1'b0;
    w_bypass      = 1'b0;
    w_rel_ok      = 1'b0;
    w_rel_err_set = 1'b0;
    w_pend_nxt    = r_pend;
    unique case (r_state)
      INIT: begin
        w_wr          = 1'b1;
        w_wdata       = r_init_addr;
        w_rel_err_set = bus.i_rel_vld;
        if (bus.i_addr_req) begin
          w_pend_nxt = 1'b1;
        end
        if (r_init_addr == LAST_ADDR) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_want        = r_pend | bus.i_addr_req;
        w_rel_ok      = bus.i_rel_vld & ~w_full;
        w_rel_err_set = bus.i_rel_vld & w_full;
        if (w_want && w_has_free) begin
          w_grant    = 1'b1;
          w_rd       = 1'b1;
          w_wr       = w_rel_ok;
          w_pend_nxt = 1'b0;
        end else if (w_want && bus.i_rel_vld) begin
          // Empty list: hand the returning block straight to the requester.
          w_bypass   = 1'b1;
          w_pend_nxt = 1'b0;
        end else begin
          w_wr       = w_rel_ok;
          w_pend_nxt = w_want;
        end
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init_addr <= '0;
      r_pend      <= 1'b0;
      r_vld       <= 1'b0;
      r_addr      <= '0;
      r_init_done <= 1'b0;
      r_req_ovf   <= 1'b0;
      r_rel_err   <= 1'b0;
    end else begin
      if (r_state == INIT) begin
        r_init_addr <= r_init_addr + 1'b1;
      end
      r_pend      <= w_pend_nxt;
      r_vld       <= w_grant | w_bypass;
      if (w_grant || w_bypass) begin
        r_addr <= w_gnt_addr;
      end
      r_init_done <= r_init_done | (r_state == RUN);
      r_req_ovf   <= r_req_ovf | w_ovf_set;
      r_rel_err   <= r_rel_err | w_rel_err_set;
    end
  end

  assign bus.o_blk_addr_vld = r_vld;
  assign bus.o_blk_addr     = r_addr;
  assign o_free_cnt         = w_cnt;
  assign o_empty            = (w_cnt == '0);
  assign o_init_done        = r_init_done;
  assign o_req_ovf          = r_req_ovf;
  assign o_rel_err          = r_rel_err;

endmodule

// File: tb/tb_blk_addr_alloc.sv
// Directed testbench for blk_addr_alloc with 16 managed blocks.
// Each scenario task drives its stimulus and checks against hand values.
module tb_blk_addr_alloc;

  logic       clk;
  logic       rst_n;
  logic [4:0] free_cnt;
  logic       empty;
  logic       init_done;
  logic       req_ovf;
  logic       rel_err;

  int checks;
  int errors;

  blk_addr_alloc_if #(.AW(4)) bus ();

  blk_addr_alloc #(
    .BLK_ADDR_WIDTH (4),
    .BLK_NUM        (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_free_cnt  (free_cnt),
    .o_empty     (empty),
    .o_init_done (init_done),
    .o_req_ovf   (req_ovf),
    .o_rel_err   (rel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_addr_req = 1'b0;
    bus.i_rel_vld  = 1'b0;
    bus.i_rel_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_init();
    repeat (17) tick();
  endtask

  task automatic req_once();
    bus.i_addr_req = 1'b1;
    tick();
    bus.i_addr_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (bus.o_blk_addr_vld !== 1'b0 || bus.o_blk_addr !== 4'd0 ||
        free_cnt !== 5'd0 || empty !== 1'b1 || init_done !== 1'b0 ||
        req_ovf !== 1'b0 || rel_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: vld=%b addr=%0d cnt=%0d empty=%b done=%b ovf=%b rerr=%b, want 0 0 0 1 0 0 0",
               tag, bus.o_blk_addr_vld, bus.o_blk_addr, free_cnt, empty,
               init_done, req_ovf, rel_err);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    check_reset_vals("reset_state");
    tick();
    check_reset_vals("reset_held");
  endtask

  task automatic test_init();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (free_cnt !== 5'(k + 1) || init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_cnt[%0d]: cnt=%0d done=%b, want %0d 0",
                 k, free_cnt, init_done, k + 1);
      end
    end
    tick();
    checks++;
    if (init_done !== 1'b1 || free_cnt !== 5'd16 || empty !== 1'b0) begin
      errors++;
      $display("FAIL init_done: done=%b cnt=%0d empty=%b, want 1 16 0",
               init_done, free_cnt, empty);
    end
  endtask

  task automatic test_rel_full();
    bus.i_rel_vld  = 1'b1;
    bus.i_rel_addr = 4'd3;
    tick();
    idle_inputs();
    checks++;
    if (rel_err !== 1'b1 || free_cnt !== 5'd16) begin
      errors++;
      $display("FAIL rel_full: rerr=%b cnt=%0d, want 1 16", rel_err, free_cnt);
    end
    tick();
    checks++;
    if (rel_err !== 1'b1) begin
      errors++;
      $display("FAIL rel_err_sticky: rerr=%b, want 1", rel_err);
    end
    req_once();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd0 ||
        free_cnt !== 5'd15) begin
      errors++;
      $display("FAIL rel_full_grant: vld=%b addr=%0d cnt=%0d, want 1 0 15",
               bus.o_blk_addr_vld, bus.o_blk_addr, free_cnt);
    end
  endtask

  task automatic test_drain_pending();
    do_reset();
    wait_init();
    for (int i = 0; i < 16; i++) begin
      req_once();
      checks++;
      if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'(i)) begin
        errors++;
        $display("FAIL drain_grant[%0d]: vld=%b addr=%0d, want 1 %0d",
                 i, bus.o_blk_addr_vld, bus.o_blk_addr, i);
      end
      tick();
      checks++;
      if (bus.o_blk_addr_vld !== 1'b0) begin
        errors++;
        $display("FAIL drain_strobe[%0d]: vld=%b, want 0", i, bus.o_blk_addr_vld);
      end
    end
    req_once();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b0 || empty !== 1'b1 || free_cnt !== 5'd0) begin
      errors++;
      $display("FAIL drain_pend: vld=%b empty=%b cnt=%0d, want 0 1 0",
               bus.o_blk_addr_vld, empty, free_cnt);
    end
    tick();
    bus.i_rel_vld  = 1'b1;
    bus.i_rel_addr = 4'd9;
    tick();
    idle_inputs();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd9 ||
        free_cnt !== 5'd0) begin
      errors++;
      $display("FAIL pend_release: vld=%b addr=%0d cnt=%0d, want 1 9 0",
               bus.o_blk_addr_vld, bus.o_blk_addr, free_cnt);
    end
  endtask

  task automatic test_bypass();
    tick();
    bus.i_addr_req = 1'b1;
    bus.i_rel_vld  = 1'b1;
    bus.i_rel_addr = 4'd5;
    tick();
    idle_inputs();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd5 ||
        free_cnt !== 5'd0) begin
      errors++;
      $display("FAIL bypass: vld=%b addr=%0d cnt=%0d, want 1 5 0",
               bus.o_blk_addr_vld, bus.o_blk_addr, free_cnt);
    end
    tick();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b0 || free_cnt !== 5'd0) begin
      errors++;
      $display("FAIL bypass_after: vld=%b cnt=%0d, want 0 0",
               bus.o_blk_addr_vld, free_cnt);
    end
  endtask

  task automatic test_ovf();
    req_once();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b0 || req_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: vld=%b ovf=%b, want 0 0", bus.o_blk_addr_vld, req_ovf);
    end
    req_once();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b0 || req_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_second: vld=%b ovf=%b, want 0 1", bus.o_blk_addr_vld, req_ovf);
    end
    bus.i_rel_vld  = 1'b1;
    bus.i_rel_addr = 4'd7;
    tick();
    idle_inputs();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd7) begin
      errors++;
      $display("FAIL ovf_grant: vld=%b addr=%0d, want 1 7",
               bus.o_blk_addr_vld, bus.o_blk_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_blk_addr_vld !== 1'b0 || req_ovf !== 1'b1 || free_cnt !== 5'd0) begin
        errors++;
        $display("FAIL ovf_single[%0d]: vld=%b ovf=%b cnt=%0d, want 0 1 0",
                 i, bus.o_blk_addr_vld, req_ovf, free_cnt);
      end
    end
  endtask

  task automatic test_simul();
    bus.i_rel_vld  = 1'b1;
    bus.i_rel_addr = 4'd10;
    tick();
    bus.i_rel_addr = 4'd11;
    tick();
    idle_inputs();
    checks++;
    if (free_cnt !== 5'd2 || bus.o_blk_addr_vld !== 1'b0) begin
      errors++;
      $display("FAIL simul_fill: cnt=%0d vld=%b, want 2 0", free_cnt, bus.o_blk_addr_vld);
    end
    bus.i_addr_req = 1'b1;
    bus.i_rel_vld  = 1'b1;
    bus.i_rel_addr = 4'd12;
    tick();
    idle_inputs();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd10 ||
        free_cnt !== 5'd2) begin
      errors++;
      $display("FAIL simul_both: vld=%b addr=%0d cnt=%0d, want 1 10 2",
               bus.o_blk_addr_vld, bus.o_blk_addr, free_cnt);
    end
    bus.i_addr_req = 1'b1;
    tick();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd11) begin
      errors++;
      $display("FAIL b2b_first: vld=%b addr=%0d, want 1 11",
               bus.o_blk_addr_vld, bus.o_blk_addr);
    end
    tick();
    bus.i_addr_req = 1'b0;
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd12 ||
        free_cnt !== 5'd0) begin
      errors++;
      $display("FAIL b2b_second: vld=%b addr=%0d cnt=%0d, want 1 12 0",
               bus.o_blk_addr_vld, bus.o_blk_addr, free_cnt);
    end
  endtask

  task automatic test_reset_mid_init();
    do_reset();
    repeat (7) tick();
    checks++;
    if (free_cnt !== 5'd7) begin
      errors++;
      $display("FAIL mid_init_cnt: cnt=%0d, want 7", free_cnt);
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_init_reset");
    tick();
    rst_n = 1'b1;
    req_once();
    checks++;
    if (free_cnt !== 5'd1 || bus.o_blk_addr_vld !== 1'b0) begin
      errors++;
      $display("FAIL init_restart: cnt=%0d vld=%b, want 1 0", free_cnt, bus.o_blk_addr_vld);
    end
    for (int k = 1; k < 16; k++) begin
      tick();
      checks++;
      if (bus.o_blk_addr_vld !== 1'b0) begin
        errors++;
        $display("FAIL init_no_grant[%0d]: vld=%b, want 0", k, bus.o_blk_addr_vld);
      end
    end
    tick();
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd0 ||
        free_cnt !== 5'd15 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_pend_grant: vld=%b addr=%0d cnt=%0d done=%b, want 1 0 15 1",
               bus.o_blk_addr_vld, bus.o_blk_addr, free_cnt, init_done);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    wait_init();
    bus.i_addr_req = 1'b1;
    repeat (16) tick();
    bus.i_addr_req = 1'b0;
    checks++;
    if (bus.o_blk_addr_vld !== 1'b1 || bus.o_blk_addr !== 4'd15 || empty !== 1'b1) begin
      errors++;
      $display("FAIL run_drain: vld=%b addr=%0d empty=%b, want 1 15 1",
               bus.o_blk_addr_vld, bus.o_blk_addr, empty);
    end
    req_once();
    req_once();
    checks++;
    if (req_ovf !== 1'b1) begin
      errors++;
      $display("FAIL run_ovf: ovf=%b, want 1", req_ovf);
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_run_reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      checks++;
      if (bus.o_blk_addr_vld !== 1'b0) begin
        errors++;
        $display("FAIL stale_grant[%0d]: vld=%b, want 0", k, bus.o_blk_addr_vld);
      end
    end
    checks++;
    if (free_cnt !== 5'd16 || init_done !== 1'b1 || req_ovf !== 1'b0) begin
      errors++;
      $display("FAIL run_reinit: cnt=%0d done=%b ovf=%b, want 16 1 0",
               free_cnt, init_done, req_ovf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_init();
    test_rel_full();
    test_drain_pending();
    test_bypass();
    test_ovf();
    test_simul();
    test_reset_mid_init();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blk_addr_alloc.md
BLK_ADDR_ALLOC -- requirements
Module: blk_addr_alloc

Interface
REQ-001 The block SHALL take BLK_ADDR_WIDTH (default `BLK_ADDR_WIDTH` from the shared header) and BLK_NUM = 2**BLK_ADDR_WIDTH, the number of SRAM blocks managed.
REQ-002 i_clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_addr_req  input  1  single-cycle pulse requesting one free block, driven by the channel's o_addr_req.
REQ-005 o_blk_addr_vld  output  1  one-cycle grant strobe, consumed by the channel's i_blk_addr_vld.
REQ-006 o_blk_addr  output  BLK_ADDR_WIDTH  granted block address, valid only while o_blk_addr_vld=1.
REQ-007 i_rel_vld  input  1  strobe returning one block to the free list (read side).
REQ-008 i_rel_addr  input  BLK_ADDR_WIDTH  address being returned.
REQ-009 o_free_cnt  output  BLK_ADDR_WIDTH+1  number of free blocks currently held.
REQ-010 o_empty  output  1  high when o_free_cnt==0.
REQ-011 o_init_done  output  1  high once the free list is fully initialised.
REQ-012 o_req_ovf  output  1  sticky error: a request arrived while one was already pending.
REQ-013 o_rel_err  output  1  sticky error: a release arrived while the list was full.

Function
REQ-014 The block SHALL have a two-state FSM, INIT and RUN; reset enters INIT.
REQ-015 In INIT, the block SHALL write address k into free-list slot k on the k-th cycle after reset release (k=0..BLK_NUM-1), incrementing o_free_cnt each cycle.
REQ-016 After the write of BLK_NUM-1, the FSM SHALL go to RUN and set o_init_done=1 on the following cycle; INIT is never re-entered without reset.
REQ-017 The free list SHALL be a circular FIFO of BLK_NUM entries with rd/wr pointers of BLK_ADDR_WIDTH bits that wrap modulo BLK_NUM.
REQ-018 A request accepted in RUN with o_free_cnt>0 SHALL yield o_blk_addr_vld=1 exactly one cycle later, with o_blk_addr = head entry; rd_ptr advances and the count decrements.
REQ-019 A request in INIT, or in RUN while empty, SHALL set a single pending flag; no grant is issued yet.
REQ-020 A pending request SHALL be granted on the first RUN cycle with a free entry, one cycle later, then cleared.
REQ-021 A request while pending=1 SHALL be dropped and SHALL set o_req_ovf.
REQ-022 A release in RUN with o_free_cnt<BLK_NUM SHALL write i_rel_addr at wr_ptr, advance wr_ptr and increment the count.
REQ-023 A release with o_free_cnt==BLK_NUM SHALL be dropped and SHALL set o_rel_err; releases during INIT are dropped with o_rel_err set.
REQ-024 A simultaneous release and grant-eligible request in one cycle SHALL both take effect; the count is unchanged.
REQ-025 If the list is empty and release plus request (or pending) coincide, the released address SHALL be bypassed to o_blk_addr next cycle, without touching the FIFO pointers.
REQ-026 At most one grant SHALL be issued per cycle, and grants SHALL occur only in RUN.
REQ-027 The block SHALL not check i_rel_addr for duplicates; that is the releasing stage's responsibility.

Reset
REQ-028 On i_rst_n=0, the block SHALL immediately set: state=INIT, pointers=0, o_free_cnt=0, o_empty=1, pending=0, o_blk_addr_vld=0, o_blk_addr=0, o_init_done=0, o_req_ovf=0, o_rel_err=0.
REQ-029 Reset mid-operation SHALL discard all outstanding grants and pending requests, and initialisation SHALL restart from address 0.
REQ-030 FIFO storage contents need not be reset; INIT rewrites every slot.

Structure
REQ-031 BLK_ADDR_WIDTH and BLK_NUM SHALL come from the shared mpcache header/package, alongside the FSM state enum typedef (INIT, RUN).
REQ-032 The storage SHALL be one sub-module, blk_free_fifo: a synchronous circular FIFO with show-ahead head output, count, and write/read strobes.
REQ-033 The top level SHALL hold the FSM, the pending flag, the bypass path and the error flags.

Verification (bench uses BLK_ADDR_WIDTH=4, BLK_NUM=16)
REQ-034 Reset release, no traffic -> addresses 0..15 written on cycles 0..15; o_init_done=1 at cycle 17; o_free_cnt=16; o_empty=0.
REQ-035 After init, 17 request pulses spaced 2 cycles -> grants 0,1,..,15, each 1 cycle after its request; the 17th sets pending and o_empty=1; release of addr 9 -> grant of 9 one cycle later.
REQ-036 Empty list, request and release of addr 5 in the same cycle -> o_blk_addr=5 with vld next cycle; o_free_cnt stays 0.
REQ-037 Full list, release of addr 3 -> o_rel_err=1 sticky; o_free_cnt stays 16; the next request is granted addr 0.
REQ-038 Empty list with pending=1, second request -> o_req_ovf=1; exactly one grant follows the next release.
REQ-039 Reset asserted mid-INIT at cycle 7 and mid-RUN with pending=1 -> all outputs return to reset values at once; after release, INIT restarts at address 0 and no stale grant appears.
